// File: rtl/fpf_encoder_12.sv
// fpf_encoder_12: Fibonacci-numeral forbidden-pattern-free encoder for a 12-TSV bundle.
// Maps 0..376 to a codeword with no 010/101 window; out-of-range inputs saturate to 376.
module fpf_encoder_12 #(
    parameter int DATA_W = 9,
    parameter int N_TSV  = 12
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] datain,
    output logic [N_TSV-1:0]  tsv
);
    localparam logic [DATA_W-1:0] W [0:N_TSV] = '{
        DATA_W'(1), DATA_W'(1), DATA_W'(2), DATA_W'(3), DATA_W'(5), DATA_W'(8), DATA_W'(13),
        DATA_W'(21), DATA_W'(34), DATA_W'(55), DATA_W'(89), DATA_W'(144), DATA_W'(233)
    };
    localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(376);
    logic [DATA_W-1:0] w_rem;
    logic [N_TSV+1:0]  w_ext;
    logic [N_TSV-1:0]  r_tsv;
    // w_ext carries two virtual zero bits above the word so the MSB steps see p=0
    always_comb begin
        w_rem = (datain > MAX_VAL) ? MAX_VAL : datain;
        w_ext = '0;
        for (int k = N_TSV - 1; k >= 0; k--) begin
            w_ext[k] = (w_ext[k+1] != w_ext[k+2]) ? w_ext[k+1] :
                       (w_ext[k+1] ? (w_rem >= W[k]) : (w_rem >= W[k+1]));
            w_rem = w_ext[k] ? w_rem - W[k] : w_rem;
        end
    end
    always_ff @(posedge clock) begin
        r_tsv <= !rst_n ? '0 : w_ext[N_TSV-1:0];
    end
    assign tsv = r_tsv;
endmodule

// File: tb/tb_fpf_encoder_12.sv
// tb_fpf_encoder_12: table-driven and scoreboard checks of the FPF encoder.
module tb_fpf_encoder_12;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  datain = '0;
    logic [11:0] tsv;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [8:0]  din;
        logic [11:0] exp;
    } vec_t;
    typedef struct {
        logic        exact;
        logic [8:0]  din;
        logic [11:0] exp;
    } sb_t;

    sb_t sb[$];
    int  fib [12] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};

    always #5 clock = ~clock;

    fpf_encoder_12 dut (
        .clock(clock),
        .rst_n(rst_n),
        .datain(datain),
        .tsv(tsv)
    );

    function automatic int decode(input logic [11:0] c);
        int s = 0;
        for (int k = 0; k < 12; k++) if (c[k]) s += fib[k];
        return s;
    endfunction

    function automatic bit forbidden(input logic [11:0] c);
        logic [2:0] win;
        for (int j = 0; j < 10; j++) begin
            win = c[j+:3];
            if (win == 3'b010 || win == 3'b101) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_out();
        sb_t s;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard empty at t=%0t", $time);
            return;
        end
        s = sb.pop_front();
        n_vec++;
        if (s.exact) begin
            if (tsv !== s.exp) begin
                n_bad++;
                $display("FAIL code din=%0d got=%h exp=%h", s.din, tsv, s.exp);
            end
        end else if (decode(tsv) != int'(s.din) || forbidden(tsv)) begin
            n_bad++;
            $display("FAIL property din=%0d got=%h decoded=%0d forbidden=%0d", s.din, tsv, decode(tsv), forbidden(tsv));
        end
    endtask

    // Drive at posedge+1, confirm the output holds before the edge, sample at next posedge+1
    task automatic apply(input logic [8:0] d, input logic ex, input logic [11:0] e);
        logic [11:0] prev;
        prev = tsv;
        datain = d;
        sb.push_back('{ex, d, e});
        #2;
        n_vec++;
        if (tsv !== prev) begin
            n_bad++;
            $display("FAIL hold din=%0d got=%h exp=%h", d, tsv, prev);
        end
        @(posedge clock);
        #1;
        check_out();
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{9'd0,   12'h000};
        tbl[1] = '{9'd1,   12'h001};
        tbl[2] = '{9'd2,   12'h003};
        tbl[3] = '{9'd200, 12'h781};
        tbl[4] = '{9'd233, 12'hC00};
        tbl[5] = '{9'd376, 12'hFFF};
        tbl[6] = '{9'd377, 12'hFFF};
        tbl[7] = '{9'd511, 12'hFFF};

        rst_n  = 1'b0;
        datain = 9'd200;
        @(posedge clock);
        #1;
        n_vec++;
        if (tsv !== 12'h000) begin
            n_bad++;
            $display("FAIL reset got=%h exp=000", tsv);
        end
        rst_n = 1'b1;
        apply(9'd200, 1'b1, 12'h781);

        for (int i = 0; i < 8; i++) apply(tbl[i].din, 1'b1, tbl[i].exp);

        apply(9'd376, 1'b1, 12'hFFF);
        apply(9'd0,   1'b1, 12'h000);

        for (int v = 0; v <= 376; v++) apply(9'(v), 1'b0, 12'h000);

        for (int i = 0; i < 10000; i++) apply(9'($urandom_range(376)), 1'b0, 12'h000);

        rst_n  = 1'b0;
        datain = 9'd376;
        @(posedge clock);
        #1;
        n_vec++;
        if (tsv !== 12'h000) begin
            n_bad++;
            $display("FAIL midreset got=%h exp=000", tsv);
        end
        rst_n = 1'b1;
        apply(9'd376, 1'b1, 12'hFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
